period_meter: RTL

- Measures the period of a slow, possibly asynchronous square wave in units of the system clock.
- Inverse of the counter-based clock division used elsewhere: the divider derives slow clocks from `clock`; this block recovers the divide ratio of a slow signal.
- Used on FPGA to confirm divided clocks and external switch/sensor rates, and as a self-check in simulation.
- Optional high-time capture gives duty cycle.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_sync_edge_detect.sv | 42 ++++
 rtl/period_meter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its input synchroniser.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } pm_state_t;

  localparam int CNT_W_DEFAULT   = 32;
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic s_sync,
  output logic rise,
  output logic fall
);

  // Fewer than two stages gives no metastability margin, so clamp upward.
  localparam int NS = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [NS-1:0] chain_q;
  logic [NS-1:0] chain_d;
  logic          prev_q;
  logic          prev_d;

  always_comb begin
    chain_d = {chain_q[NS-2:0], d};
    prev_d  = chain_q[NS-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign s_sync = chain_q[NS-1];
  assign rise   = s_sync & ~prev_q;
  assign fall   = ~s_sync & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in system-clock cycles.
// Define DUTY_MEASURE_EN to also capture the high time of each period.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s_sync;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (sig_in),
    .s_sync  (s_sync),
    .rise    (rise),
    .fall    (fall)
  );

  pm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

`ifdef DUTY_MEASURE_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             unused_fall;
  assign unused_fall = fall;
`else
  logic             unused_sync;
  assign unused_sync = ^{fall, s_sync};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef DUTY_MEASURE_EN
    hcnt_d    = hcnt_q;
    high_d    = high_q;
`endif
    // Disable overrides everything, including a rise in the same cycle.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef DUTY_MEASURE_EN
      hcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM, STALL: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
`ifdef DUTY_MEASURE_EN
            hcnt_d  = CNT_ONE;
`endif
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
`ifdef DUTY_MEASURE_EN
            high_d    = hcnt_q;
            hcnt_d    = CNT_ONE;
`endif
          end else if (cnt_q == CNT_MAX
`ifdef DUTY_MEASURE_EN
                       || hcnt_q == CNT_MAX
`endif
                      ) begin
            timeout_d = 1'b1;
            state_d   = STALL;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
`ifdef DUTY_MEASURE_EN
            hcnt_d = hcnt_q + CNT_W'(s_sync);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DUTY_MEASURE_EN
      hcnt_q    <= '0;
      high_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
`ifdef DUTY_MEASURE_EN
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
`endif
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
`ifdef DUTY_MEASURE_EN
  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

endmodule
